zebra_frame_scheduler: RTL and testbench

//  Sequences the zebra-crossing pipeline on a single shared frame BRAM:

---
 rtl/zebra_frame_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_zebra_frame_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zebra_frame_scheduler.sv
// Frame scheduler for the zebra-crossing pipeline.
// Captures one greyscale frame into a shared BRAM, starts the detector,
// hands it the BRAM ports while it runs, then latches its results.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   enable                           permits new captures to start
//   pix_valid/pix_sof/pix_data       camera pixel stream
//   mem_rd_addr/mem_rd_data          BRAM read port (2-cycle read latency)
//   mem_we/mem_wr_addr/mem_wr_data   BRAM write port
//   det_start/det_done               detector handshake
//   det_rd_addr/det_rd_data          detector read port (forwarded)
//   det_we/det_wr_addr/det_wr_data   detector write port (forwarded in DETECT)
//   det_zebra/det_blob_count         detector results, valid with det_done
//   zebra_detected/blob_count        latched results of last detection
//   result_valid                     one-cycle pulse when results update
//   busy                             high whenever not idle
//   det_timeout                      sticky abort flag
//   frames_dropped                   saturating count of lost SOFs
module zebra_frame_scheduler #(
  parameter int unsigned IMG_WIDTH      = 640,
  parameter int unsigned IMG_HEIGHT     = 480,
  parameter int unsigned W              = 8,
  parameter int unsigned DECIMATION     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  localparam int unsigned N             = IMG_WIDTH * IMG_HEIGHT,
  localparam int unsigned A             = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          pix_valid,
  input  logic          pix_sof,
  input  logic [W-1:0]  pix_data,
  output logic [A-1:0]  mem_rd_addr,
  input  logic [W-1:0]  mem_rd_data,
  output logic          mem_we,
  output logic [A-1:0]  mem_wr_addr,
  output logic [W-1:0]  mem_wr_data,
  output logic          det_start,
  input  logic          det_done,
  input  logic [A-1:0]  det_rd_addr,
  output logic [W-1:0]  det_rd_data,
  input  logic          det_we,
  input  logic [A-1:0]  det_wr_addr,
  input  logic [7:0]    det_wr_data,
  input  logic          det_zebra,
  input  logic [7:0]    det_blob_count,
  output logic          zebra_detected,
  output logic [7:0]    blob_count,
  output logic          result_valid,
  output logic          busy,
  output logic          det_timeout,
  output logic [15:0]   frames_dropped
);

  localparam int unsigned DW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [A-1:0]  LAST_ADDR = A'(N - 1);
  localparam logic [DW-1:0] DEC_LAST  = DW'(DECIMATION - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    START   = 2'd2,
    DETECT  = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [A-1:0]  wr_addr, wr_addr_next;
  logic [DW-1:0] dec_cnt, dec_cnt_next;
  logic [TW-1:0] to_cnt, to_cnt_next;
  logic          zebra_next;
  logic [7:0]    blob_next;
  logic          rv_next;
  logic          timeout_next;
  logic [15:0]   dropped_next;
  logic          drop_evt;
  logic          sof_seen;

  assign sof_seen    = pix_valid & pix_sof;
  assign det_start   = (state == START);
  assign busy        = (state != IDLE);
  assign det_rd_data = mem_rd_data;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr        <= '0;
      dec_cnt        <= '0;
      to_cnt         <= '0;
      zebra_detected <= 1'b0;
      blob_count     <= '0;
      result_valid   <= 1'b0;
      det_timeout    <= 1'b0;
      frames_dropped <= '0;
    end else begin
      wr_addr        <= wr_addr_next;
      dec_cnt        <= dec_cnt_next;
      to_cnt         <= to_cnt_next;
      zebra_detected <= zebra_next;
      blob_count     <= blob_next;
      result_valid   <= rv_next;
      det_timeout    <= timeout_next;
      frames_dropped <= dropped_next;
    end
  end

  // Next-state, BRAM port mux and register updates
  always_comb begin
    state_next   = state;
    wr_addr_next = wr_addr;
    dec_cnt_next = dec_cnt;
    to_cnt_next  = to_cnt;
    zebra_next   = zebra_detected;
    blob_next    = blob_count;
    rv_next      = 1'b0;
    timeout_next = det_timeout;
    drop_evt     = 1'b0;
    mem_rd_addr  = '0;
    mem_we       = 1'b0;
    mem_wr_addr  = '0;
    mem_wr_data  = '0;

    unique case (state)
      IDLE: begin
        // Only every DECIMATION-th accepted SOF starts a capture.
        if (sof_seen && enable) begin
          if (dec_cnt == DEC_LAST) begin
            dec_cnt_next = '0;
            mem_we       = 1'b1;
            mem_wr_data  = pix_data;
            wr_addr_next = A'(1);
            state_next   = CAPTURE;
          end else begin
            dec_cnt_next = dec_cnt + DW'(1);
          end
        end
      end
      CAPTURE: begin
        if (pix_valid) begin
          mem_we      = 1'b1;
          mem_wr_data = pix_data;
          if (pix_sof) begin
            // New frame overrides the partial one.
            wr_addr_next = A'(1);
            drop_evt     = 1'b1;
          end else begin
            mem_wr_addr = wr_addr;
            if (wr_addr == LAST_ADDR) begin
              state_next = START;
            end else begin
              wr_addr_next = wr_addr + A'(1);
            end
          end
        end
      end
      START: begin
        to_cnt_next = '0;
        drop_evt    = sof_seen;
        state_next  = DETECT;
      end
      DETECT: begin
        mem_rd_addr = det_rd_addr;
        mem_we      = det_we;
        mem_wr_addr = det_wr_addr;
        mem_wr_data = W'(det_wr_data);
        drop_evt    = sof_seen;
        if (det_done) begin
          zebra_next   = det_zebra;
          blob_next    = det_blob_count;
          rv_next      = 1'b1;
          timeout_next = 1'b0;
          state_next   = IDLE;
        end else if (to_cnt == TO_LAST) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          to_cnt_next = to_cnt + TW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    dropped_next = (drop_evt && (frames_dropped != 16'hFFFF)) ?
                   frames_dropped + 16'd1 : frames_dropped;
  end

endmodule

// File: tb/tb_zebra_frame_scheduler.sv
// Bench for zebra_frame_scheduler: two instances (DECIMATION 1 and 3) share
// one stimulus stream; a frame-level model predicts every output each cycle.
module tb_zebra_frame_scheduler;

  localparam int NPIX = 32;
  localparam int TO   = 64;
  localparam int P_IDLE = 0, P_CAP = 1, P_START = 2, P_DET = 3;

  typedef struct packed {
    int phase; int idx; int dec_cnt; int age;
    int zebra; int blobs; int rv; int tout; int dropped;
  } mstate_t;

  typedef struct packed {
    int rd_addr; int we; int wr_addr; int wr_data; int start; int rd_data;
    int zebra; int blobs; int rv; int busy; int tout; int dropped;
  } outs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, enable, pix_valid, pix_sof, det_done, det_we, det_zebra;
  logic [7:0] pix_data, mem_rd_data, det_wr_data, det_blob_count;
  logic [4:0] det_rd_addr, det_wr_addr;

  logic [4:0]  a_rd_addr, a_wr_addr, b_rd_addr, b_wr_addr;
  logic [7:0]  a_wr_data, a_rd_data, a_blob, b_wr_data, b_rd_data, b_blob;
  logic        a_we, a_start, a_zebra, a_rv, a_busy, a_tout;
  logic        b_we, b_start, b_zebra, b_rv, b_busy, b_tout;
  logic [15:0] a_dropped, b_dropped;

  zebra_frame_scheduler #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .W(8), .DECIMATION(1),
                          .TIMEOUT_CYCLES(64)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_data(pix_data), .mem_rd_addr(a_rd_addr),
    .mem_rd_data(mem_rd_data), .mem_we(a_we), .mem_wr_addr(a_wr_addr),
    .mem_wr_data(a_wr_data), .det_start(a_start), .det_done(det_done),
    .det_rd_addr(det_rd_addr), .det_rd_data(a_rd_data), .det_we(det_we),
    .det_wr_addr(det_wr_addr), .det_wr_data(det_wr_data), .det_zebra(det_zebra),
    .det_blob_count(det_blob_count), .zebra_detected(a_zebra), .blob_count(a_blob),
    .result_valid(a_rv), .busy(a_busy), .det_timeout(a_tout),
    .frames_dropped(a_dropped));

  zebra_frame_scheduler #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .W(8), .DECIMATION(3),
                          .TIMEOUT_CYCLES(64)) dut3 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_data(pix_data), .mem_rd_addr(b_rd_addr),
    .mem_rd_data(mem_rd_data), .mem_we(b_we), .mem_wr_addr(b_wr_addr),
    .mem_wr_data(b_wr_data), .det_start(b_start), .det_done(det_done),
    .det_rd_addr(det_rd_addr), .det_rd_data(b_rd_data), .det_we(det_we),
    .det_wr_addr(det_wr_addr), .det_wr_data(det_wr_data), .det_zebra(det_zebra),
    .det_blob_count(det_blob_count), .zebra_detected(b_zebra), .blob_count(b_blob),
    .result_valid(b_rv), .busy(b_busy), .det_timeout(b_tout),
    .frames_dropped(b_dropped));

  int total = 0;
  int bad   = 0;
  mstate_t m1, m3;
  int start1 = 0, start3 = 0, rv1 = 0;
  int wcount [NPIX];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Outputs implied by the frame-level state plus the current inputs.
  function automatic outs_t model_outs(input mstate_t s, input int dec);
    outs_t e = '0;
    e.rd_data = int'(mem_rd_data);
    e.start   = (s.phase == P_START) ? 1 : 0;
    e.busy    = (s.phase != P_IDLE) ? 1 : 0;
    e.zebra   = s.zebra;
    e.blobs   = s.blobs;
    e.rv      = s.rv;
    e.tout    = s.tout;
    e.dropped = s.dropped;
    if (s.phase == P_IDLE) begin
      if (pix_valid && pix_sof && enable && s.dec_cnt == dec - 1) begin
        e.we = 1; e.wr_addr = 0; e.wr_data = int'(pix_data);
      end
    end else if (s.phase == P_CAP) begin
      if (pix_valid) begin
        e.we = 1; e.wr_addr = pix_sof ? 0 : s.idx; e.wr_data = int'(pix_data);
      end
    end else if (s.phase == P_DET) begin
      e.rd_addr = int'(det_rd_addr);
      e.we      = det_we ? 1 : 0;
      e.wr_addr = int'(det_wr_addr);
      e.wr_data = int'(det_wr_data);
    end
    return e;
  endfunction

  // Advance the frame-level state by one clock.
  function automatic mstate_t model_step(input mstate_t s, input int dec);
    mstate_t n = s;
    bit sofv = pix_valid && pix_sof;
    n.rv = 0;
    if (s.phase == P_IDLE) begin
      if (sofv && enable) begin
        if (s.dec_cnt == dec - 1) begin
          n.dec_cnt = 0; n.phase = P_CAP; n.idx = 1;
        end else n.dec_cnt = s.dec_cnt + 1;
      end
    end else if (s.phase == P_CAP) begin
      if (pix_valid) begin
        if (pix_sof) begin
          n.idx = 1;
          n.dropped = (s.dropped < 65535) ? s.dropped + 1 : 65535;
        end else if (s.idx == NPIX - 1) n.phase = P_START;
        else n.idx = s.idx + 1;
      end
    end else begin
      if (sofv) n.dropped = (s.dropped < 65535) ? s.dropped + 1 : 65535;
      if (s.phase == P_START) begin
        n.phase = P_DET; n.age = 0;
      end else if (det_done) begin
        n.zebra = det_zebra ? 1 : 0; n.blobs = int'(det_blob_count);
        n.rv = 1; n.tout = 0; n.phase = P_IDLE;
      end else if (s.age == TO - 1) begin
        n.tout = 1; n.phase = P_IDLE;
      end else n.age = s.age + 1;
    end
    return n;
  endfunction

  task automatic cmp(input string tag, input outs_t a, input outs_t e);
    chk({tag, ".mem_rd_addr"}, a.rd_addr, e.rd_addr);
    chk({tag, ".mem_we"}, a.we, e.we);
    if (e.we != 0) begin
      chk({tag, ".mem_wr_addr"}, a.wr_addr, e.wr_addr);
      chk({tag, ".mem_wr_data"}, a.wr_data, e.wr_data);
    end
    chk({tag, ".det_start"}, a.start, e.start);
    chk({tag, ".det_rd_data"}, a.rd_data, e.rd_data);
    chk({tag, ".zebra_detected"}, a.zebra, e.zebra);
    chk({tag, ".blob_count"}, a.blobs, e.blobs);
    chk({tag, ".result_valid"}, a.rv, e.rv);
    chk({tag, ".busy"}, a.busy, e.busy);
    chk({tag, ".det_timeout"}, a.tout, e.tout);
    chk({tag, ".frames_dropped"}, a.dropped, e.dropped);
  endtask

  // Compare process: inputs are stable at the falling edge.
  always @(negedge clk) begin
    outs_t a1, a3;
    if (!rst_n) begin
      m1 = '0;
      m3 = '0;
    end
    a1 = '{int'(a_rd_addr), int'(a_we), int'(a_wr_addr), int'(a_wr_data),
           int'(a_start), int'(a_rd_data), int'(a_zebra), int'(a_blob),
           int'(a_rv), int'(a_busy), int'(a_tout), int'(a_dropped)};
    a3 = '{int'(b_rd_addr), int'(b_we), int'(b_wr_addr), int'(b_wr_data),
           int'(b_start), int'(b_rd_data), int'(b_zebra), int'(b_blob),
           int'(b_rv), int'(b_busy), int'(b_tout), int'(b_dropped)};
    cmp("dec1", a1, model_outs(m1, 1));
    cmp("dec3", a3, model_outs(m3, 3));
    if (rst_n) begin
      if (a_start) start1++;
      if (b_start) start3++;
      if (a_rv) rv1++;
      if (a_we) wcount[a_wr_addr]++;
      m1 = model_step(m1, 1);
      m3 = model_step(m3, 3);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    enable = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 8'($urandom);
    det_done = 1'b0; det_zebra = 1'b0; det_blob_count = 8'h00;
    det_we = 1'b0; det_wr_addr = 5'($urandom); det_wr_data = 8'($urandom);
    det_rd_addr = 5'($urandom); mem_rd_data = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin clear_in(); tick(); end
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic send_pixels(input int n, input bit first_sof);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) begin clear_in(); tick(); end
      clear_in();
      pix_valid = 1'b1;
      pix_sof   = (i == 0) && first_sof;
      tick();
    end
    clear_in();
  endtask

  task automatic done_pulse(input bit z, input int blobs);
    clear_in();
    det_done = 1'b1; det_zebra = z; det_blob_count = 8'(blobs);
    tick();
    clear_in();
  endtask

  initial begin
    int snap [NPIX];
    int s1, s3, r1;
    for (int i = 0; i < NPIX; i++) wcount[i] = 0;
    clear_in();
    rst_n = 1'b0;
    tick(); tick(); tick();
    chk("reset.busy", int'(a_busy), 0);
    chk("reset.frames_dropped", int'(a_dropped), 0);
    rst_n = 1'b1;
    idle(2);

    // Full frame: each address written exactly once, one start pulse.
    snap = wcount;
    s1 = start1;
    send_pixels(NPIX, 1'b1);
    idle(3);
    for (int i = 0; i < NPIX; i++) chk($sformatf("writes_addr%0d", i), wcount[i] - snap[i], 1);
    chk("start_pulses_frame1", start1 - s1, 1);
    chk("busy_in_detect", int'(a_busy), 1);

    // Good detection result.
    r1 = rv1;
    done_pulse(1'b1, 5);
    idle(2);
    chk("zebra_after_done", int'(a_zebra), 1);
    chk("blob_after_done", int'(a_blob), 5);
    chk("busy_after_done", int'(a_busy), 0);
    chk("result_valid_pulses", rv1 - r1, 1);

    // Timeout, then a good detection clears it.
    send_pixels(NPIX, 1'b1);
    idle(72);
    chk("timeout_set", int'(a_tout), 1);
    chk("busy_after_timeout", int'(a_busy), 0);
    send_pixels(NPIX, 1'b1);
    idle(2);
    done_pulse(1'b0, 9);
    idle(2);
    chk("timeout_cleared", int'(a_tout), 0);
    chk("blob_second", int'(a_blob), 9);

    // Mid-capture restart, then SOFs and detector writes during DETECT.
    send_pixels(10, 1'b1);
    send_pixels(NPIX, 1'b1);
    idle(3);
    chk("dropped_restart", int'(a_dropped), 1);
    for (int i = 0; i < 5; i++) begin
      clear_in();
      pix_valid = (i < 3);
      pix_sof   = (i < 3);
      det_we    = 1'b1;
      tick();
    end
    idle(1);
    chk("dropped_in_detect", int'(a_dropped), 4);
    done_pulse(1'b1, 3);
    idle(2);

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        clear_in();
        enable         = ($urandom_range(0, 9) != 0);
        pix_valid      = 1'($urandom);
        pix_sof        = ($urandom_range(0, 39) == 0);
        det_done       = ($urandom_range(0, 29) == 0);
        det_zebra      = 1'($urandom);
        det_blob_count = 8'($urandom);
        det_we         = 1'($urandom);
        tick();
      end
    end

    // Decimation: six frames give two detections on the DECIMATION=3 instance.
    do_reset();
    idle(2);
    s1 = start1;
    s3 = start3;
    for (int f = 0; f < 6; f++) begin
      send_pixels(NPIX, 1'b1);
      idle(3);
      done_pulse(1'b1, f);
      idle(2);
    end
    chk("dec3_start_pulses", start3 - s3, 2);
    chk("dec1_start_pulses", start1 - s1, 6);
    chk("dec3_dropped", int'(b_dropped), 0);
    chk("dec1_dropped", int'(a_dropped), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
